axi_response_router: RTL and testbench

AXI_RESPONSE_ROUTER -- requirements
Module: axi_response_router

---
 rtl/axi_node_pkg.sv | 16 +
 rtl/axi_response_fifo2.sv | 61 ++++++
 rtl/axi_response_router.sv | 108 ++++++++++
 tb/tb_axi_response_router.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
// Shared constants for the AXI node response path.
//   FIFO_DEPTH    : number of buffered responses in the response FIFO
//   ERR_CNT_WIDTH : width of the saturating dropped-response counter
//   sat_inc       : saturating increment for the error counter
package axi_node_pkg;

    localparam int FIFO_DEPTH    = 2;
    localparam int ERR_CNT_WIDTH = 8;

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        logic [ERR_CNT_WIDTH-1:0] r;
        r = (v == '1) ? v : v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/axi_response_fifo2.sv
// Generic in-order FIFO of FIFO_DEPTH (2) entries.
// Ports:
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push       : write push_data (ignored while full)
//   push_data  : entry to enqueue
//   pop        : drop the head entry (ignored while empty)
//   full/empty : occupancy flags, driven from the count register only
//   head_data  : current head entry (undefined while empty)
module axi_response_fifo2
    import axi_node_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axi_response_router.sv
// Routes incoming AXI responses to one of N_MASTER master ports using the
// master index carried in the top LOG_MASTER bits of the response ID.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   data_req_i    : incoming response valid
//   data_AUX_i    : incoming payload
//   data_ID_i     : incoming ID (master index in the top bits)
//   data_gnt_o    : incoming response accepted (FIFO not full)
//   data_req_o    : per-master response valid (one-hot or zero)
//   data_AUX_o    : head payload broadcast to every master slice
//   data_ID_o     : head ID with index stripped, broadcast to every slice
//   data_gnt_i    : per-master ready
//   clear_err_i   : clears err_o / err_cnt_o
//   err_o         : sticky out-of-range-index flag
//   err_cnt_o     : saturating count of dropped responses
module axi_response_router
    import axi_node_pkg::*;
#(
    parameter int AUX_WIDTH  = 64,
    parameter int ID_WIDTH   = 20,
    parameter int N_MASTER   = 5,
    parameter int LOG_MASTER = $clog2(N_MASTER)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     data_req_i,
    input  logic [AUX_WIDTH-1:0]                     data_AUX_i,
    input  logic [ID_WIDTH-1:0]                      data_ID_i,
    output logic                                     data_gnt_o,
    output logic [N_MASTER-1:0]                      data_req_o,
    output logic [N_MASTER*AUX_WIDTH-1:0]            data_AUX_o,
    output logic [N_MASTER*(ID_WIDTH-LOG_MASTER)-1:0] data_ID_o,
    input  logic [N_MASTER-1:0]                      data_gnt_i,
    input  logic                                     clear_err_i,
    output logic                                     err_o,
    output logic [ERR_CNT_WIDTH-1:0]                 err_cnt_o
);

    localparam int SID_W   = ID_WIDTH - LOG_MASTER;
    localparam int ENTRY_W = LOG_MASTER + SID_W + AUX_WIDTH;

    logic [LOG_MASTER-1:0] in_idx;
    logic                  in_range;
    logic                  accept;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    push_data;
    logic [ENTRY_W-1:0]    head_data;
    logic [LOG_MASTER-1:0] head_idx;
    logic [SID_W-1:0]      head_id;
    logic [AUX_WIDTH-1:0]  head_aux;

    assign in_idx    = data_ID_i[ID_WIDTH-1 -: LOG_MASTER];
    assign in_range  = (int'(in_idx) < N_MASTER);
    assign accept    = data_req_i && data_gnt_o;
    assign push      = accept && in_range;
    assign drop      = accept && !in_range;
    assign push_data = {in_idx, data_ID_i[SID_W-1:0], data_AUX_i};

    // Full comes straight from the FIFO count register, so the input-side
    // grant never depends combinationally on any master's ready.
    assign data_gnt_o = !fifo_full;

    axi_response_fifo2 #(
        .WIDTH(ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_data(head_data)
    );

    assign {head_idx, head_id, head_aux} = head_data;

    always_comb begin
        data_req_o = '0;
        for (int m = 0; m < N_MASTER; m++) begin
            data_req_o[m] = !fifo_empty && (int'(head_idx) == m);
        end
    end

    // Masking with data_req_o ignores ready from masters that are not the target.
    assign pop = |(data_req_o & data_gnt_i);

    assign data_AUX_o = {N_MASTER{head_aux}};
    assign data_ID_o  = {N_MASTER{head_id}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else if (clear_err_i) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else if (drop) begin
            err_o     <= 1'b1;
            err_cnt_o <= sat_inc(err_cnt_o);
        end
    end

endmodule

// File: tb/tb_axi_response_router.sv
module tb_axi_response_router;

    localparam int AUX_WIDTH  = 64;
    localparam int ID_WIDTH   = 20;
    localparam int N_MASTER   = 5;
    localparam int LOG_MASTER = 3;
    localparam int SW         = ID_WIDTH - LOG_MASTER;

    logic                          clk;
    logic                          rst_n;
    logic                          data_req_i;
    logic [AUX_WIDTH-1:0]          data_AUX_i;
    logic [ID_WIDTH-1:0]           data_ID_i;
    logic                          data_gnt_o;
    logic [N_MASTER-1:0]           data_req_o;
    logic [N_MASTER*AUX_WIDTH-1:0] data_AUX_o;
    logic [N_MASTER*SW-1:0]        data_ID_o;
    logic [N_MASTER-1:0]           data_gnt_i;
    logic                          clear_err_i;
    logic                          err_o;
    logic [7:0]                    err_cnt_o;

    int errors = 0;
    int checks = 0;

    axi_response_router #(
        .AUX_WIDTH (AUX_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .N_MASTER  (N_MASTER),
        .LOG_MASTER(LOG_MASTER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_req_i (data_req_i),
        .data_AUX_i (data_AUX_i),
        .data_ID_i  (data_ID_i),
        .data_gnt_o (data_gnt_o),
        .data_req_o (data_req_o),
        .data_AUX_o (data_AUX_o),
        .data_ID_o  (data_ID_o),
        .data_gnt_i (data_gnt_i),
        .clear_err_i(clear_err_i),
        .err_o      (err_o),
        .err_cnt_o  (err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic req, input logic [ID_WIDTH-1:0] id, input logic [AUX_WIDTH-1:0] aux);
        data_req_i = req;
        data_ID_i  = id;
        data_AUX_i = aux;
    endtask

    function automatic logic [AUX_WIDTH-1:0] aux_of(input int m);
        return data_AUX_o[m*AUX_WIDTH +: AUX_WIDTH];
    endfunction

    function automatic logic [SW-1:0] id_of(input int m);
        return data_ID_o[m*SW +: SW];
    endfunction

    initial begin
        rst_n       = 1'b0;
        clear_err_i = 1'b0;
        data_gnt_i  = '0;
        drive(1'b0, '0, '0);

        // reset state
        #2;
        chk("rst_req", data_req_o, 5'b00000);
        chk("rst_gnt", data_gnt_o, 1'b1);
        chk("rst_err", err_o, 1'b0);
        chk("rst_cnt", err_cnt_o, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // routing to master 2
        drive(1'b1, 20'h40123, 64'hA5);
        chk("route_pre_req", data_req_o, 5'b00000);
        tick();
        drive(1'b0, '0, '0);
        chk("route_req", data_req_o, 5'b00100);
        chk("route_id", id_of(2), 17'h00123);
        chk("route_aux", aux_of(2), 64'hA5);
        chk("route_gnt", data_gnt_o, 1'b1);
        data_gnt_i = 5'b00100;
        tick();
        chk("route_pop", data_req_o, 5'b00000);
        data_gnt_i = '0;

        // backpressure on master 0
        drive(1'b1, 20'h00001, 64'h11);
        tick();
        chk("bp_gnt1", data_gnt_o, 1'b1);
        chk("bp_req1", data_req_o, 5'b00001);
        drive(1'b1, 20'h00002, 64'h22);
        tick();
        chk("bp_full", data_gnt_o, 1'b0);
        drive(1'b1, 20'h00003, 64'h33);
        tick();
        chk("bp_full2", data_gnt_o, 1'b0);
        chk("bp_hold_req", data_req_o, 5'b00001);
        chk("bp_hold_aux", aux_of(0), 64'h11);
        tick();
        chk("bp_hold_aux2", aux_of(0), 64'h11);
        chk("bp_hold_id", id_of(0), 17'h00001);
        data_gnt_i = 5'b00001;
        tick();
        chk("bp_second", aux_of(0), 64'h22);
        chk("bp_gnt_free", data_gnt_o, 1'b1);
        tick();
        drive(1'b0, '0, '0);
        chk("bp_third", aux_of(0), 64'h33);
        chk("bp_third_req", data_req_o, 5'b00001);
        tick();
        chk("bp_drain", data_req_o, 5'b00000);
        data_gnt_i = '0;

        // streaming alternating masters 1 / 4
        data_gnt_i = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, ((k % 2 == 0) ? 20'h20000 : 20'h80000) | 20'(k), 64'h100 + 64'(k));
            chk("stream_gnt_in", data_gnt_o, 1'b1);
            tick();
            chk("stream_req", data_req_o, (k % 2 == 0) ? 5'b00010 : 5'b10000);
            chk("stream_aux", aux_of((k % 2 == 0) ? 1 : 4), 64'h100 + 64'(k));
            chk("stream_gnt", data_gnt_o, 1'b1);
        end
        drive(1'b0, '0, '0);
        tick();
        chk("stream_end", data_req_o, 5'b00000);
        data_gnt_i = '0;

        // out-of-range drops
        drive(1'b1, 20'hE0000, 64'hDEAD);
        tick();
        drive(1'b0, '0, '0);
        chk("drop_req", data_req_o, 5'b00000);
        chk("drop_err", err_o, 1'b1);
        chk("drop_cnt", err_cnt_o, 8'd1);
        chk("drop_gnt", data_gnt_o, 1'b1);
        drive(1'b1, 20'hA0000, 64'h5);
        tick();
        drive(1'b0, '0, '0);
        chk("drop_idx5_cnt", err_cnt_o, 8'd2);
        chk("drop_idx5_req", data_req_o, 5'b00000);
        drive(1'b1, 20'hE0000, 64'h0);
        for (int k = 0; k < 298; k++) tick();
        drive(1'b0, '0, '0);
        chk("drop_sat", err_cnt_o, 8'd255);
        chk("drop_sat_err", err_o, 1'b1);
        clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        chk("clr_err", err_o, 1'b0);
        chk("clr_cnt", err_cnt_o, 8'd0);
        clear_err_i = 1'b1;
        drive(1'b1, 20'hE0000, 64'h0);
        tick();
        clear_err_i = 1'b0;
        drive(1'b0, '0, '0);
        chk("clr_wins_err", err_o, 1'b0);
        chk("clr_wins_cnt", err_cnt_o, 8'd0);
        tick();
        chk("clr_wins_cnt2", err_cnt_o, 8'd0);

        // head-of-line blocking
        drive(1'b1, 20'h60033, 64'h3);
        tick();
        drive(1'b1, 20'h20011, 64'h1);
        tick();
        drive(1'b0, '0, '0);
        chk("hol_head", data_req_o, 5'b01000);
        data_gnt_i = 5'b00010;
        tick();
        chk("hol_blocked", data_req_o, 5'b01000);
        chk("hol_blocked_aux", aux_of(3), 64'h3);
        data_gnt_i = 5'b01000;
        tick();
        chk("hol_next", data_req_o, 5'b00010);
        chk("hol_next_id", id_of(1), 17'h00011);
        data_gnt_i = 5'b00010;
        tick();
        chk("hol_drain", data_req_o, 5'b00000);
        data_gnt_i = '0;

        // async reset with two entries buffered and a sticky error
        drive(1'b1, 20'hE0000, 64'h0);
        tick();
        drive(1'b1, 20'h40001, 64'h71);
        tick();
        drive(1'b1, 20'h40002, 64'h72);
        tick();
        drive(1'b0, '0, '0);
        chk("ar_full", data_gnt_o, 1'b0);
        chk("ar_err_set", err_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", data_req_o, 5'b00000);
        chk("ar_gnt", data_gnt_o, 1'b1);
        chk("ar_err", err_o, 1'b0);
        chk("ar_cnt", err_cnt_o, 8'd0);
        tick();
        rst_n = 1'b1;
        data_gnt_i = 5'b11111;
        tick();
        chk("ar_noreplay1", data_req_o, 5'b00000);
        tick();
        chk("ar_noreplay2", data_req_o, 5'b00000);
        chk("ar_gnt_after", data_gnt_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
